// File: rtl/pwm_duty_decoder_if.sv
// Pin-side and result-side signals of the PWM duty decoder.
// master = decoder, slave = the logic that drives the line and consumes results.
interface pwm_duty_decoder_if #(
   parameter int CNT_W = 24
);
   logic             pwm_in;
   logic [6:0]       duty_pct;
   logic [2:0]       level;
   logic [CNT_W-1:0] period;
   logic             valid;
   logic             stuck;
   logic             overrun;

   modport master (
      input  pwm_in,
      output duty_pct, level, period, valid, stuck, overrun
   );

   modport slave (
      output pwm_in,
      input  duty_pct, level, period, valid, stuck, overrun
   );
endinterface

// File: rtl/pwm_duty_decoder.sv
// Measures period and high time of a PWM line, divides to duty percent and quantizes to level 0..4.
// Optional macro PWM_DECODE_AVG_EN: average over 4 accepted periods before dividing.
module pwm_duty_decoder #(
   parameter int CNT_W   = 24,
   parameter int TIMEOUT = 2000000
) (
   input logic                clk,
   input logic                reset_n,
   pwm_duty_decoder_if.master bus
);

`ifdef PWM_DECODE_AVG_EN
   localparam int ACC_W = CNT_W + 2;
`else
   localparam int ACC_W = CNT_W;
`endif
   localparam int NUM_W = ACC_W + 7;

   typedef enum logic {SYNC, MEAS} state_t;

   function automatic logic [6:0] sat_pct(input logic [6:0] q);
      return (q > 7'd100) ? 7'd100 : q;
   endfunction

   // Decision points sit halfway between the nominal 5/25/50/75/100 % levels.
   function automatic logic [2:0] level_of(input logic [6:0] d);
      if (d < 7'd15)      return 3'd0;
      else if (d < 7'd38) return 3'd1;
      else if (d < 7'd63) return 3'd2;
      else if (d < 7'd88) return 3'd3;
      else                return 3'd4;
   endfunction

   function automatic logic [CNT_W-1:0] period_of(input logic [ACC_W-1:0] d);
`ifdef PWM_DECODE_AVG_EN
      return CNT_W'(d >> 2);
`else
      return d;
`endif
   endfunction

   logic             sync_p0, sync_p1, sync_p2;
   logic             line, rise;
   state_t           state;
   logic [CNT_W-1:0] high_cnt, per_cnt;
   logic [NUM_W-1:0] rem, den_sh, rem_nxt;
   logic [ACC_W-1:0] den;
   logic [6:0]       quo, quo_nxt, pct;
   logic [3:0]       step;
   logic [2:0]       bit_idx;
   logic             busy, ge;

`ifdef PWM_DECODE_AVG_EN
   logic [ACC_W-1:0] acc_high, acc_per, sum_high, sum_per;
   logic [1:0]       acc_cnt;

   assign sum_high = acc_high + ACC_W'(high_cnt);
   assign sum_per  = acc_per + ACC_W'(per_cnt);
`endif

   assign line = sync_p1;
   assign rise = sync_p1 & ~sync_p2;

   // step 1..7 resolves quotient bits 6..0; step 8 is the result cycle.
   assign busy    = (step != 4'd0);
   assign bit_idx = 3'(4'd7 - step);
   assign den_sh  = NUM_W'(den) << bit_idx;
   assign ge      = (rem >= den_sh);
   assign rem_nxt = ge ? (rem - den_sh) : rem;
   assign quo_nxt = quo | (ge ? (7'd1 << bit_idx) : 7'd0);
   assign pct     = sat_pct(quo_nxt);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_p0      <= 1'b0;
         sync_p1      <= 1'b0;
         sync_p2      <= 1'b0;
         state        <= SYNC;
         high_cnt     <= '0;
         per_cnt      <= '0;
         rem          <= '0;
         den          <= '0;
         quo          <= '0;
         step         <= '0;
         bus.duty_pct <= '0;
         bus.level    <= '0;
         bus.period   <= '0;
         bus.valid    <= 1'b0;
         bus.stuck    <= 1'b0;
         bus.overrun  <= 1'b0;
`ifdef PWM_DECODE_AVG_EN
         acc_high     <= '0;
         acc_per      <= '0;
         acc_cnt      <= '0;
`endif
      end else begin
         // stage p0/p1: metastability filter; p2: previous value for edge detect
         sync_p0   <= bus.pwm_in;
         sync_p1   <= sync_p0;
         sync_p2   <= sync_p1;
         bus.valid <= 1'b0;

         // divider stage: one restoring step per cycle
         if (busy) begin
            if (step != 4'd8) begin
               rem <= rem_nxt;
               quo <= quo_nxt;
            end
            if (step == 4'd7) begin
               bus.duty_pct <= pct;
               bus.level    <= level_of(pct);
               bus.period   <= period_of(den);
               bus.valid    <= 1'b1;
               bus.stuck    <= 1'b0;
            end
            step <= (step == 4'd8) ? 4'd0 : step + 4'd1;
         end

         // measurement stage: the rising-edge cycle counts as cycle 1 of the new period
         case (state)
            SYNC: begin
               if (rise) begin
                  high_cnt <= CNT_W'(1);
                  per_cnt  <= CNT_W'(1);
                  state    <= MEAS;
               end
            end
            MEAS: begin
               if (rise) begin
                  high_cnt <= CNT_W'(1);
                  per_cnt  <= CNT_W'(1);
                  if (busy) begin
                     bus.overrun <= 1'b1;
`ifdef PWM_DECODE_AVG_EN
                     acc_high    <= '0;
                     acc_per     <= '0;
                     acc_cnt     <= '0;
`endif
                  end else begin
`ifdef PWM_DECODE_AVG_EN
                     if (acc_cnt == 2'd3) begin
                        rem      <= NUM_W'(sum_high) * NUM_W'(100);
                        den      <= sum_per;
                        quo      <= '0;
                        step     <= 4'd1;
                        acc_high <= '0;
                        acc_per  <= '0;
                        acc_cnt  <= '0;
                     end else begin
                        acc_high <= sum_high;
                        acc_per  <= sum_per;
                        acc_cnt  <= acc_cnt + 2'd1;
                     end
`else
                     rem  <= NUM_W'(high_cnt) * NUM_W'(100);
                     den  <= per_cnt;
                     quo  <= '0;
                     step <= 4'd1;
`endif
                  end
               end else if (per_cnt >= CNT_W'(TIMEOUT)) begin
                  // static line: report 0 % or 100 % directly, bypassing the divider
                  bus.duty_pct <= line ? 7'd100 : 7'd0;
                  bus.level    <= line ? 3'd4 : 3'd0;
                  bus.period   <= '0;
                  bus.stuck    <= 1'b1;
                  bus.valid    <= 1'b1;
                  state        <= SYNC;
`ifdef PWM_DECODE_AVG_EN
                  acc_high     <= '0;
                  acc_per      <= '0;
                  acc_cnt      <= '0;
`endif
               end else begin
                  per_cnt  <= per_cnt + CNT_W'(1);
                  high_cnt <= high_cnt + CNT_W'(line);
               end
            end
            default: state <= SYNC;
         endcase
      end
   end

endmodule

// File: tb/tb_pwm_duty_decoder.sv
// Randomized and directed bench for pwm_duty_decoder with a scoreboard fed by a
// period-level reference model (duty = high*100/period, divider busy for 8 cycles).
module tb_pwm_duty_decoder;
   localparam int CNT_W   = 24;
   localparam int TIMEOUT = 1000;
   localparam int LAT     = 10;   // pin rise (driven at negedge) to valid sample

   logic clk = 1'b0;
   logic reset_n = 1'b0;

   pwm_duty_decoder_if #(.CNT_W(CNT_W)) bus ();

   pwm_duty_decoder #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int duty;
      int level;
      int period;
      int stuck;
      int t;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;

   // reference model state
   bit   m_meas;
   bit   m_have_acc;
   bit   m_ovr;
   int   m_last_acc;
   int   m_prev_h;
   int   m_prev_p;

   function automatic void check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
      end
   endfunction

   function automatic int ref_level(input int d);
      if (d < 15)      return 0;
      else if (d < 38) return 1;
      else if (d < 63) return 2;
      else if (d < 88) return 3;
      else             return 4;
   endfunction

   // A rising edge of the line ends the previous period.
   function automatic void model_edge();
      exp_t e;
      if (!m_meas) begin
         m_meas = 1'b1;
      end else if (m_have_acc && (cyc - m_last_acc) < 9) begin
         m_ovr = 1'b1;
      end else begin
         m_have_acc = 1'b1;
         m_last_acc = cyc;
         e.duty   = (m_prev_h * 100) / m_prev_p;
         e.level  = ref_level(e.duty);
         e.period = m_prev_p;
         e.stuck  = 0;
         e.t      = cyc + LAT;
         exp_q.push_back(e);
      end
   endfunction

   task automatic drive_period(input int h, input int p);
      @(negedge clk);
      model_edge();
      bus.pwm_in = 1'b1;
      m_prev_h = h;
      m_prev_p = p;
      for (int i = 1; i < p; i++) begin
         @(negedge clk);
         bus.pwm_in = (i < h);
      end
   endtask

   task automatic drive_low(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         bus.pwm_in = 1'b0;
         m_prev_p++;
      end
   endtask

   task automatic hold_high(input int n);
      exp_t e;
      @(negedge clk);
      model_edge();
      bus.pwm_in = 1'b1;
      e.duty = 100; e.level = 4; e.period = 0; e.stuck = 1; e.t = -1;
      exp_q.push_back(e);
      m_meas = 1'b0;
      repeat (n - 1) @(negedge clk);
   endtask

   task automatic check_zero_outputs(input string tag);
      check({tag, "_duty"},    int'(bus.duty_pct), 0);
      check({tag, "_level"},   int'(bus.level),    0);
      check({tag, "_period"},  int'(bus.period),   0);
      check({tag, "_valid"},   int'(bus.valid),    0);
      check({tag, "_stuck"},   int'(bus.stuck),    0);
      check({tag, "_overrun"}, int'(bus.overrun),  0);
   endtask

   task automatic release_reset();
      exp_q.delete();
      m_meas = 1'b0; m_have_acc = 1'b0; m_ovr = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      bus.pwm_in = 1'b0;
      reset_n = 1'b0;
      #1;
      check_zero_outputs(tag);
      release_reset();
   endtask

   task automatic wait_drain(input string tag);
      int k = 0;
      while (exp_q.size() != 0 && k < 60) begin
         @(negedge clk);
         bus.pwm_in = 1'b0;
         m_prev_p++;
         k++;
      end
      check({tag, "_drain"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   // monitor: pops one expectation per valid pulse
   initial begin
      exp_t e;
      int   last_v = -1000;
      forever begin
         @(posedge clk);
         cyc++;
         #1;
         if (reset_n && bus.valid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_valid", 1, 0);
            end else begin
               e = exp_q.pop_front();
               check("duty_pct", int'(bus.duty_pct), e.duty);
               check("level",    int'(bus.level),    e.level);
               check("period",   int'(bus.period),   e.period);
               check("stuck",    int'(bus.stuck),    e.stuck);
               if (e.t >= 0) check("latency", cyc, e.t);
            end
            check("valid_spacing_ge8", int'((cyc - last_v) >= 8), 1);
            last_v = cyc;
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int bh[8];
      int h, p;
      bh = '{37, 38, 14, 88, 15, 62, 63, 87};
      bus.pwm_in = 1'b0;
      do_reset("reset_init");

      // steady 25/75: first edge only synchronizes
      repeat (5) drive_period(25, 100);

      for (int i = 0; i < 8; i++) drive_period(bh[i], 100);

      // timeout with line high, then resume 50/50 period 20
      hold_high(TIMEOUT + 200);
      check("stuck_after_timeout", int'(bus.stuck), 1);
      drive_low(10);
      repeat (3) drive_period(10, 20);
      wait_drain("timeout");
      check("stuck_cleared", int'(bus.stuck), 0);
      check("overrun_none", int'(bus.overrun), int'(m_ovr));

      // reset in the middle of a division
      repeat (2) drive_period(20, 40);
      @(negedge clk);
      model_edge();
      bus.pwm_in = 1'b1;
      repeat (6) @(negedge clk);
      reset_n = 1'b0;
      bus.pwm_in = 1'b0;
      #1;
      check_zero_outputs("reset_middiv");
      release_reset();
      repeat (3) drive_period(30, 60);
      wait_drain("after_reset");
      check("overrun_after_reset", int'(bus.overrun), int'(m_ovr));

      // overrun: period too short for the divider
      repeat (12) drive_period(2, 4);
      wait_drain("overrun");
      check("overrun_set", int'(bus.overrun), int'(m_ovr));
      check("overrun_model", int'(m_ovr), 1);

      // randomized periods, mixing accepted and dropped captures
      for (int i = 0; i < 40; i++) begin
         p = $urandom_range(80, 2);
         h = $urandom_range(p - 1, 1);
         drive_period(h, p);
      end
      drive_period(5, 10);
      wait_drain("random");
      check("overrun_random", int'(bus.overrun), int'(m_ovr));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/pwm_duty_decoder.md
Name: pwm_duty_decoder

Overview:
- Receive side of the LED PWM scheme: measures an incoming PWM waveform and reports its period, duty cycle in percent, and the nearest brightness level.
- Brightness levels 0..4 correspond to duty cycles of 5/25/50/75/100 %.
- Used for loopback checking of the LED PWM output and for decoding external dimmer inputs.
- Sits between an input pin and the control logic; one clock domain.

Parameters:
- CNT_W, 24: width of the high-time and period counters; must hold TIMEOUT.
- TIMEOUT, 2000000: clk cycles without a rising edge before the line is declared static.

Ports:
- clk  input  1  system clock, 100 MHz
- reset_n  input  1  asynchronous active-low reset
- pwm_in  input  1  asynchronous PWM line
- duty_pct  output  7  last measured duty cycle, 0..100
- level  output  3  quantized brightness level, 0..4
- period  output  CNT_W  last measured period in clk cycles
- valid  output  1  one-cycle pulse when duty_pct, level and period update
- stuck  output  1  high while the line is static (timeout)
- overrun  output  1  sticky: a measurement was dropped because the divider was busy

Behaviour:
- Reset, asynchronous, active-low. All outputs, counters, synchronizer flops and FSM state go to 0 / SYNC. Reset mid-division aborts the division; no valid is produced.
- Input path: 2-flop synchronizer, then a third flop for edge detection. A rising edge is seen 3 cycles after the pin toggles.
- Measurement FSM states: SYNC, MEAS.
  - SYNC: waits for a rising edge, then clears high_cnt and per_cnt and enters MEAS. No result is produced.
  - MEAS: per_cnt increments every cycle; high_cnt increments when the synced line is 1. The edge cycle counts as cycle 1.
  - A rising edge in MEAS is the capture cycle C:
    - If the divider is idle, it latches high_cnt and per_cnt.
    - If the divider is busy, the sample is discarded and overrun is set.
    - Either way, both counters restart at 1 / line value; the state stays MEAS.
  - If per_cnt reaches TIMEOUT with no rising edge:
    - Without starting the divider, load duty_pct = 100 if the line is 1, else 0; level = 4 or 0; period = 0.
    - Set stuck = 1, pulse valid once, go to SYNC.
    - Counters therefore never exceed TIMEOUT.
- Divider:
  - Restoring division: numerator = high*100 (CNT_W+7 bits), denominator = period.
  - Quotient bits 6..0, one bit per cycle, in cycles C+1..C+7.
  - Results are registered and valid is high in cycle C+8; busy covers C+1..C+8.
  - The quotient truncates toward zero and is always ≤ 100.
  - stuck clears in the same cycle valid rises for a divider result.
- Level quantization, using the midpoints of 5/25/50/75/100:
  - duty < 15 → 0
  - 15 ≤ duty < 38 → 1
  - 38 ≤ duty < 63 → 2
  - 63 ≤ duty < 88 → 3
  - duty ≥ 88 → 4
- Outputs hold their values between valid pulses.
- overrun clears only on reset.

Optional Feature:
- Macro: PWM_DECODE_AVG_EN.
- With the macro defined:
  - Captured high and period values are accumulated over 4 consecutive accepted periods; accumulators are CNT_W+2 bits.
  - The divider runs on the sums; period output = sum >> 2.
  - valid pulses once per 4 accepted periods.
  - A timeout or overrun clears the accumulator and the 4-count.
- Without the macro: every accepted period is divided individually, as above.

Test Plan:
- Reset: pulse reset_n low mid-simulation → all outputs 0 immediately, without waiting for a clk edge.
- Steady 25-high/75-low, period 100 → first valid 8 cycles after the 2nd synced rising edge; duty_pct=25, level=1, period=100, stuck=0; repeats every 100 cycles.
- Level boundaries, period 100:
  - high 37 → duty 37, level 1
  - high 38 → level 2
  - high 14 → level 0
  - high 88 → level 4
  - high 100 (line held high) → handled by the timeout test.
- Timeout, TIMEOUT=1000: drive line constant 1 after a valid PWM → exactly one valid; duty_pct=100, level=4, stuck=1. Restart PWM 50/50 period 20 → next valid gives duty=50, level=2, stuck=0.
- Overrun: 2-high/2-low period 4 → overrun=1; every produced result has duty_pct=50, period=4; valid spacing ≥ 8 cycles.
- Reset mid-division: assert reset_n low at C+4 → no valid, outputs 0, overrun 0. After release, the first result appears only after SYNC plus one full period.
